// File: rtl/csi2_pkg.sv
// rtl/csi2_pkg.sv - CSI-2 transmit shared types, data types, ECC and CRC helpers
package csi2_pkg;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_RAW10 = 6'h2B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SP,
        ST_LP_HDR,
        ST_LP_PAY,
        ST_LP_CRC,
        ST_GAP
    } state_t;

    // Hamming parity over {data_hi, data_lo, DI}; the two top bits are always zero.
    function automatic logic [7:0] ecc24(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^ d[16]
             ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^ d[17]
             ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^ d[18]
             ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[19]
             ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
             ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
             ^ d[21] ^ d[22] ^ d[23];
        return {2'b00, p};
    endfunction

    // One payload byte through the reflected x^16+x^12+x^5+1 CRC, LSB first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 16'h8408;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/csi2_raw10_packer.sv
// rtl/csi2_raw10_packer.sv - RAW10 4-pixel to 5-byte packer, valid/ready on both sides
module csi2_raw10_packer (
    input  logic       display_clk,
    input  logic       reset_n_byte,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [9:0] pix_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic [7:0] byte_data
);

    logic [1:0] idx;
    logic [7:0] lsb;
    logic       lsb_due;
    logic       drain;

    // The output register is free when empty or being taken this cycle; the
    // low-bit byte of a group always goes out before the next group starts.
    assign drain     = !byte_valid || byte_ready;
    assign pix_ready = drain && !lsb_due;

    // Emit each pixel's MSBs immediately, collect LSBs, then emit the LSB byte.
    always_ff @(posedge display_clk or negedge reset_n_byte) begin
        if (!reset_n_byte) begin
            idx        <= 2'd0;
            lsb        <= 8'h00;
            lsb_due    <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
        end else begin
            if (byte_valid && byte_ready) byte_valid <= 1'b0;
            if (lsb_due && drain) begin
                byte_data  <= lsb;
                byte_valid <= 1'b1;
                lsb_due    <= 1'b0;
            end else if (pix_valid && pix_ready) begin
                byte_data               <= pix_data[9:2];
                byte_valid              <= 1'b1;
                lsb[{idx, 1'b0} +: 2]   <= pix_data[1:0];
                idx                     <= idx + 2'd1;
                if (idx == 2'd3) lsb_due <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/csi2_packet_tx.sv
// rtl/csi2_packet_tx.sv - CSI-2 packet encoder: FS/FE short packets and RAW10 line packets
module csi2_packet_tx
    import csi2_pkg::*;
#(
    parameter int LINE_PIXELS  = 256,
    parameter int VC           = 0,
    parameter int FRAME_NUM_EN = 1,
    parameter int LP_GAP       = 8
) (
    input  logic       display_clk,
    input  logic       reset_n_byte,
    input  logic       fs_req,
    input  logic       fe_req,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [9:0] pix_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic [7:0] byte_data,
    output logic       hs_req,
    output logic       busy
);

    localparam logic [15:0] WC       = 16'(LINE_PIXELS * 5 / 4);
    localparam logic [15:0] NPIX     = 16'(LINE_PIXELS);
    localparam logic [15:0] GAP_LAST = 16'(LP_GAP - 1);
    localparam logic [1:0]  VC_BITS  = 2'(VC);

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] pix_cnt;
    logic [15:0] gap_cnt;
    logic [15:0] frame_num;
    logic [15:0] frame_next;
    logic [15:0] crc;
    logic [23:0] hdr;
    logic [7:0]  hdr_byte;
    logic        pend_fs;
    logic        pend_fe;
    logic        in_pay;
    logic        pix_left;
    logic        accept;
    logic        clr_fs;
    logic        clr_fe;
    logic        pk_in_valid;
    logic        pk_in_ready;
    logic        pk_out_valid;
    logic        pk_out_ready;
    logic [7:0]  pk_out_data;

    assign in_pay       = (state == ST_LP_PAY);
    assign pix_left     = (pix_cnt != NPIX);
    assign pk_in_valid  = pix_valid && in_pay && pix_left;
    assign pix_ready    = pk_in_ready && in_pay && pix_left;
    assign pk_out_ready = byte_ready && in_pay;
    assign byte_valid   = (state == ST_SP) || (state == ST_LP_HDR) || (state == ST_LP_CRC)
                        || (in_pay && pk_out_valid);
    assign accept       = byte_valid && byte_ready;
    assign busy         = ((state != ST_IDLE) && (state != ST_GAP)) || pend_fs || pend_fe;
    assign frame_next   = (frame_num == 16'hFFFF) ? 16'h0001 : frame_num + 16'h0001;
    assign clr_fs       = accept && (state == ST_SP) && (cnt == 16'd0) && (hdr[5:0] == DT_FS);
    assign clr_fe       = accept && (state == ST_SP) && (cnt == 16'd0) && (hdr[5:0] == DT_FE);

    csi2_raw10_packer u_packer (
        .display_clk  (display_clk),
        .reset_n_byte (reset_n_byte),
        .pix_valid    (pk_in_valid),
        .pix_ready    (pk_in_ready),
        .pix_data     (pix_data),
        .byte_valid   (pk_out_valid),
        .byte_ready   (pk_out_ready),
        .byte_data    (pk_out_data)
    );

    // Header byte selected by position: DI, data/WC low, data/WC high, ECC.
    always_comb begin
        hdr_byte = 8'h00;
        case (cnt[1:0])
            2'd0:    hdr_byte = hdr[7:0];
            2'd1:    hdr_byte = hdr[15:8];
            2'd2:    hdr_byte = hdr[23:16];
            default: hdr_byte = ecc24(hdr);
        endcase
    end

    // Output byte source follows the packet section currently being sent.
    always_comb begin
        byte_data = 8'h00;
        case (state)
            ST_SP, ST_LP_HDR: byte_data = hdr_byte;
            ST_LP_PAY:        byte_data = pk_out_data;
            ST_LP_CRC:        byte_data = cnt[0] ? crc[15:8] : crc[7:0];
            default:          byte_data = 8'h00;
        endcase
    end

    // Sticky frame requests; a new pulse wins over the clear of an older one.
    always_ff @(posedge display_clk or negedge reset_n_byte) begin
        if (!reset_n_byte) begin
            pend_fs <= 1'b0;
            pend_fe <= 1'b0;
        end else begin
            pend_fs <= fs_req | (pend_fs & ~clr_fs);
            pend_fe <= fe_req | (pend_fe & ~clr_fe);
        end
    end

    // Packet sequencer: selection, byte counting, CRC, frame number and gap timing.
    always_ff @(posedge display_clk or negedge reset_n_byte) begin
        if (!reset_n_byte) begin
            state     <= ST_IDLE;
            cnt       <= 16'd0;
            pix_cnt   <= 16'd0;
            gap_cnt   <= 16'd0;
            frame_num <= 16'd0;
            crc       <= 16'hFFFF;
            hdr       <= 24'd0;
            hs_req    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= 16'd0;
                    if (pend_fe) begin
                        state  <= ST_SP;
                        hs_req <= 1'b1;
                        hdr    <= {(FRAME_NUM_EN != 0) ? frame_num : 16'h0000, VC_BITS, DT_FE};
                    end else if (pend_fs) begin
                        state     <= ST_SP;
                        hs_req    <= 1'b1;
                        frame_num <= frame_next;
                        hdr       <= {(FRAME_NUM_EN != 0) ? frame_next : 16'h0000, VC_BITS, DT_FS};
                    end else if (pix_valid) begin
                        state   <= ST_LP_HDR;
                        hs_req  <= 1'b1;
                        crc     <= 16'hFFFF;
                        pix_cnt <= 16'd0;
                        hdr     <= {WC, VC_BITS, DT_RAW10};
                    end
                end
                ST_SP, ST_LP_HDR: begin
                    if (accept) begin
                        if (cnt == 16'd3) begin
                            cnt <= 16'd0;
                            if (state == ST_SP) begin
                                state   <= ST_GAP;
                                hs_req  <= 1'b0;
                                gap_cnt <= 16'd0;
                            end else begin
                                state <= ST_LP_PAY;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                ST_LP_PAY: begin
                    if (pk_in_valid && pk_in_ready) pix_cnt <= pix_cnt + 16'd1;
                    if (accept) begin
                        crc <= crc16_step(crc, pk_out_data);
                        if (cnt == WC - 16'd1) begin
                            cnt   <= 16'd0;
                            state <= ST_LP_CRC;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                ST_LP_CRC: begin
                    if (accept) begin
                        if (cnt == 16'd1) begin
                            cnt     <= 16'd0;
                            state   <= ST_GAP;
                            hs_req  <= 1'b0;
                            gap_cnt <= 16'd0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) state <= ST_IDLE;
                    else                     gap_cnt <= gap_cnt + 16'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
